// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - single-outstanding instruction fetch unit with redirect flush and small instruction FIFO
`timescale 1ns/1ps

module instruction_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] next_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   count;
    logic               outstanding;
    logic               drop;
    logic [31:0]        pending_pc;
    logic [PTR_W-1:0]   rd_ptr, wr_ptr;
    logic [31:0]        buf_instr [BUF_DEPTH];
    logic [31:0]        buf_pc    [BUF_DEPTH];

    logic               has_space;
    logic               grant;
    logic               resp_fire;
    logic               push;
    logic               pop;
    logic [1:0]         redirect_pc_unused;

    assign redirect_pc_unused = redirect_pc[1:0];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(BUF_DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    // A dropped response still occupies the memory port, so requests also wait on it.
    assign has_space = (32'(count) + 32'(outstanding)) < 32'(BUF_DEPTH);

    always_comb begin
        state_next = state;
        imem_req   = 1'b0;
        case (state)
            IDLE: state_next = REQ;
            REQ: begin
                imem_req = has_space & ~outstanding;
                if (imem_req && imem_gnt && !redirect) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (redirect || imem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
        if (reset) begin
            imem_req   = 1'b0;
            state_next = IDLE;
        end
    end

    assign imem_addr = {pc_in[31:2], 2'b00};
    assign grant     = imem_req & imem_gnt;
    assign resp_fire = outstanding & imem_rvalid;
    assign push      = resp_fire & ~drop & ~redirect;
    assign pop       = instr_valid & instr_ready & ~redirect;

    always_comb begin
        if (reset) begin
            next_pc = RESET_PC;
        end else if (redirect) begin
            next_pc = {redirect_pc[31:2], 2'b00};
        end else if (grant) begin
            next_pc = pc_in + 32'd4;
        end else begin
            next_pc = pc_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            outstanding <= 1'b0;
            drop        <= 1'b0;
            pending_pc  <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
        end else begin
            state <= state_next;

            if (grant) begin
                outstanding <= 1'b1;
                pending_pc  <= pc_in;
                drop        <= redirect;
            end else if (resp_fire) begin
                outstanding <= 1'b0;
                drop        <= 1'b0;
            end else if (redirect && outstanding) begin
                drop <= 1'b1;
            end

            if (redirect) begin
                count  <= '0;
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_inc(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_inc(rd_ptr);
                end
                case ({push, pop})
                    2'b10:   count <= count + CNT_W'(1);
                    2'b01:   count <= count - CNT_W'(1);
                    default: count <= count;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[wr_ptr] <= imem_rdata;
            buf_pc[wr_ptr]    <= pending_pc;
        end
    end

    assign instr_valid = ~reset & (count != '0);
    assign instr       = instr_valid ? buf_instr[rd_ptr] : '0;
    assign instr_pc    = instr_valid ? buf_pc[rd_ptr]    : '0;

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch with a modelled PC register and memory
`timescale 1ns/1ps

module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in;
    logic [31:0] next_pc;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int vectors    = 0;
    int miscompares = 0;

    logic [63:0] exp_q [$];
    logic [31:0] seen_pc [$];

    // stimulus knobs applied at every falling edge
    logic        k_reset = 1'b1;
    logic        k_redir = 1'b0;
    logic [31:0] k_redir_pc = '0;
    logic        k_gnt = 1'b0;
    logic        k_ready = 1'b0;
    logic        k_force_rvalid = 1'b0;
    int          k_delay = 1;

    logic        pend_valid = 1'b0;
    logic        pend_drop = 1'b0;
    logic [31:0] pend_addr = '0;
    int          pend_cnt = 0;

    always #5 clk = ~clk;

    // program counter register owned by the core
    always @(posedge clk) pc_in <= next_pc;

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .pc_in       (pc_in),
        .next_pc     (next_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_ready (instr_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] addr);
        return addr ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        logic resp_now;
        @(negedge clk);
        reset       = k_reset;
        redirect    = k_redir;
        redirect_pc = k_redir_pc;
        imem_gnt    = k_gnt;
        instr_ready = k_ready;
        resp_now    = 1'b0;
        if (pend_valid) begin
            pend_cnt--;
            if (pend_cnt == 0) resp_now = 1'b1;
        end
        imem_rvalid = resp_now | k_force_rvalid;
        imem_rdata  = resp_now ? mem_word(pend_addr) : (k_force_rvalid ? 32'hDEAD_BEEF : 32'h0);
        #1;
        if (reset) begin
            pend_valid = 1'b0;
            exp_q.delete();
        end else begin
            if (resp_now) begin
                if (!pend_drop && !redirect) exp_q.push_back({mem_word(pend_addr), pend_addr});
                pend_valid = 1'b0;
            end else if (pend_valid && redirect) begin
                pend_drop = 1'b1;
            end
            if (imem_req && imem_gnt) begin
                pend_valid = 1'b1;
                pend_addr  = imem_addr;
                pend_cnt   = k_delay;
                pend_drop  = redirect;
            end
        end
    endtask

    task automatic drain();
        k_gnt = 1'b0;
        k_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            step();
            if (exp_q.size() == 0 && !pend_valid && !instr_valid) break;
        end
        check("drain_left", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic wait_grant(input string name);
        logic got;
        got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (imem_req && imem_gnt) begin
                got = 1'b1;
                break;
            end
        end
        check(name, {31'b0, got}, 32'd1);
    endtask

    task automatic do_redirect(input logic [31:0] target);
        k_redir = 1'b1;
        k_redir_pc = target;
        step();
        k_redir = 1'b0;
    endtask

    // scoreboard monitor
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (reset !== 1'b1) begin
                if (redirect) begin
                    exp_q.delete();
                end else if (instr_valid && instr_ready) begin
                    if (exp_q.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL pop_unexpected: got instr_pc %h, expected no valid instruction", instr_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check("pop_pc", instr_pc, e[31:0]);
                        check("pop_instr", instr, e[63:32]);
                        seen_pc.push_back(instr_pc);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish, expected finish before 200000ns");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; redirect = 1'b0; redirect_pc = '0; imem_gnt = 1'b0;
        imem_rvalid = 1'b0; imem_rdata = '0; instr_ready = 1'b0;

        // reset state
        step();
        step();
        check("rst_next_pc", next_pc, 32'h0);
        check("rst_imem_req", {31'b0, imem_req}, 32'd0);
        check("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);

        // basic streaming fetch from address 0
        k_reset = 1'b0; k_gnt = 1'b1; k_ready = 1'b1; k_delay = 1;
        step();
        check("first_cycle_req", {31'b0, imem_req}, 32'd0);
        step();
        check("grant_req", {31'b0, imem_req}, 32'd1);
        check("grant_addr", imem_addr, 32'h0);
        check("grant_next_pc", next_pc, 32'h4);
        seen_pc.delete();
        for (int i = 0; i < 8; i++) step();
        drain();
        check("seq_len_ok", {31'b0, seen_pc.size() >= 3}, 32'd1);
        if (seen_pc.size() >= 3) begin
            check("seq_pc0", seen_pc[0], 32'h0);
            check("seq_pc1", seen_pc[1], 32'h4);
            check("seq_pc2", seen_pc[2], 32'h8);
        end

        // buffer fills to depth with decode stalled
        do_redirect(32'h0000_0040);
        k_gnt = 1'b1; k_ready = 1'b0; k_delay = 1;
        for (int i = 0; i < 10; i++) step();
        check("full_valid", {31'b0, instr_valid}, 32'd1);
        check("full_req", {31'b0, imem_req}, 32'd0);
        check("full_next_pc", next_pc, 32'h48);
        check("full_head_pc", instr_pc, 32'h40);
        k_ready = 1'b1;
        step();
        check("pop_cycle_req", {31'b0, imem_req}, 32'd0);
        k_ready = 1'b0;
        step();
        check("refill_req", {31'b0, imem_req}, 32'd1);
        check("refill_addr", imem_addr, 32'h48);
        check("refill_next_pc", next_pc, 32'h4C);
        check("refill_head_pc", instr_pc, 32'h44);
        drain();

        // redirect while waiting for a slow response
        k_gnt = 1'b1; k_ready = 1'b1; k_delay = 3;
        wait_grant("wait_grant_s3");
        step();
        do_redirect(32'h0000_0103);
        check("redir_next_pc", next_pc, 32'h100);
        step();
        check("redir_flushed", {31'b0, instr_valid}, 32'd0);
        begin
            logic got;
            got = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (instr_valid) begin
                    got = 1'b1;
                    break;
                end
                step();
            end
            check("redir_valid_seen", {31'b0, got}, 32'd1);
            check("redir_instr_pc", instr_pc, 32'h100);
            check("redir_instr", instr, 32'hC0DE_0100);
        end
        drain();

        // address wrap at the top of the space
        do_redirect(32'hFFFF_FFFC);
        k_gnt = 1'b1; k_ready = 1'b1; k_delay = 1;
        seen_pc.delete();
        wait_grant("wait_grant_wrap");
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        check("wrap_next_pc", next_pc, 32'h0);
        for (int i = 0; i < 4; i++) step();
        drain();
        check("wrap_len_ok", {31'b0, seen_pc.size() >= 2}, 32'd1);
        if (seen_pc.size() >= 2) begin
            check("wrap_pc0", seen_pc[0], 32'hFFFF_FFFC);
            check("wrap_pc1", seen_pc[1], 32'h0);
        end

        // request held stable while grant withheld
        do_redirect(32'h0000_0200);
        for (int i = 0; i < 5; i++) begin
            step();
            check("hold_req", {31'b0, imem_req}, 32'd1);
            check("hold_addr", imem_addr, 32'h200);
            check("hold_next_pc", next_pc, 32'h200);
        end
        k_gnt = 1'b1;
        step();
        check("hold_release_next_pc", next_pc, 32'h204);
        drain();

        // reset in the middle of a transaction, then stray responses
        k_gnt = 1'b1; k_delay = 3;
        wait_grant("wait_grant_rst");
        step();
        k_reset = 1'b1;
        step();
        check("mid_rst_valid", {31'b0, instr_valid}, 32'd0);
        check("mid_rst_next_pc", next_pc, 32'h0);
        check("mid_rst_req", {31'b0, imem_req}, 32'd0);
        k_reset = 1'b0; k_gnt = 1'b0; k_force_rvalid = 1'b1;
        step();
        step();
        k_force_rvalid = 1'b0;
        step();
        check("late_rvalid_valid", {31'b0, instr_valid}, 32'd0);
        check("late_rvalid_next_pc", next_pc, 32'h0);
        step();
        check("late_rvalid_valid2", {31'b0, instr_valid}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
